eth_fcs_checker: RTL and testbench
==================================

ETH_FCS_CHECKER -- requirements
Module: eth_fcs_checker

Interface
REQ-001 The block SHALL have parameter MAX_LEN, default 1518, maximum legal frame length in bytes including FCS.
REQ-002 The block SHALL have parameter MIN_LEN, default 64, minimum legal frame length in bytes including FCS.
REQ-003 The block SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port s_data  input  8  received frame byte, DA through last FCS byte, no preamble/SFD.
REQ-006 The block SHALL have port s_valid  input  1  s_data valid this cycle; may deassert anywhere mid-frame.
REQ-007 The block SHALL have port s_last  input  1  qualifies the final FCS byte of the frame; ignored when s_valid=0.
REQ-008 The block SHALL have port m_data  output  8  payload byte, FCS stripped.
REQ-009 The block SHALL have port m_valid  output  1  m_data valid.
REQ-010 The block SHALL have port m_last  output  1  last payload byte of the frame.
REQ-011 The block SHALL have port frame_done  output  1  one-cycle pulse; status outputs valid.
REQ-012 The block SHALL have port fcs_ok  output  1  FCS residue matched; valid with frame_done.
REQ-013 The block SHALL have port runt  output  1  frame length < MIN_LEN; valid with frame_done.
REQ-014 The block SHALL have port oversize  output  1  frame length > MAX_LEN; valid with frame_done.

Function
REQ-015 The CRC register SHALL use IEEE 802.3 CRC-32 in reflected form (poly 0xEDB88320, LSB-first), init 0xFFFFFFFF, updated one byte per accepted beat.
REQ-016 Every accepted byte, including all four FCS bytes, SHALL enter the CRC.
REQ-017 fcs_ok SHALL be 1 iff the CRC value after the s_last byte equals residue 0xDEBB20E3.
REQ-018 A 4-byte delay line SHALL hold the most recent accepted bytes, so the trailing four bytes (FCS) are never forwarded.
REQ-019 The FSM SHALL have states IDLE (0 bytes of frame), FILL (1-4 bytes buffered) and STREAM (>4 bytes accepted).
REQ-020 Transitions: IDLE->FILL on first accepted byte; FILL->STREAM on 5th byte; any state->IDLE on accepted byte with s_last=1.
REQ-021 In STREAM, each accepted byte SHALL release the byte accepted four beats earlier on m_data with m_valid=1, registered, one cycle after acceptance.
REQ-022 m_last SHALL assert with the payload byte released by the s_last beat; frame_done, fcs_ok, runt and oversize SHALL be registered and valid in that same cycle (latency 1 after s_last).
REQ-023 Frames of 1-4 bytes SHALL produce no m_valid beats, a frame_done pulse, runt=1, and fcs_ok per REQ-017.
REQ-024 The byte counter SHALL be 11 bits and saturate at 2047; it SHALL not wrap.
REQ-025 A byte with s_valid=1 in the cycle after s_last SHALL start a new frame with CRC reinitialised; back-to-back frames SHALL lose no bytes.
REQ-026 Cycles with s_valid=0 SHALL hold all state and drive m_valid=0.
REQ-027 There is no backpressure; the sink SHALL accept every m_valid beat.

Reset
REQ-028 With rst_n=0 at a clock edge: FSM->IDLE, CRC->0xFFFFFFFF, counter->0, delay line->0.
REQ-029 Reset values: m_data=0x00, m_valid=0, m_last=0, frame_done=0, fcs_ok=0, runt=0, oversize=0.
REQ-030 Reset mid-frame SHALL discard the partial frame silently; no frame_done for it.

Configuration
REQ-031 Macro ETH_FCS_CHECK_LEN_EN defined: byte counter and runt/oversize logic SHALL be built per REQ-013/014/024.
REQ-032 Macro ETH_FCS_CHECK_LEN_EN undefined: counter SHALL be omitted and runt and oversize SHALL be constant 0; all other behaviour unchanged.

Verification
REQ-033 Frame "123456789" (0x31..0x39) followed by 26 39 F4 CB, s_last on 0xCB -> 9 m_valid beats 0x31..0x39, m_last on 0x39, frame_done with fcs_ok=1, runt=1.
REQ-034 Same frame with FCS byte 0xCB changed to 0xCA -> identical payload output, fcs_ok=0.
REQ-035 64-byte frame with correct FCS, s_valid toggled every other cycle -> 60 payload beats, fcs_ok=1, runt=0, oversize=0.
REQ-036 Two 64-byte good frames back-to-back (no idle cycle) -> 120 payload beats, two frame_done pulses, both fcs_ok=1.
REQ-037 1519-byte frame -> oversize=1; 2100-byte frame -> oversize=1, counter held at 2047; rst_n=0 at byte 30 of a frame -> no frame_done, next frame checked correctly.

Source files
------------

// File: rtl/eth_fcs_checker.sv
// Ethernet FCS checker: strips the 4-byte FCS, checks the CRC-32 residue, optional runt/oversize (ETH_FCS_CHECK_LEN_EN).
// Latency: payload beats and frame status are registered, 1 cycle after the accepting input beat.
// Backpressure: none; every s_valid byte is accepted and the sink must take every m_valid beat.
module eth_fcs_checker #(
    parameter int MAX_LEN = 1518,
    parameter int MIN_LEN = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_last,
    output logic       frame_done,
    output logic       fcs_ok,
    output logic       runt,
    output logic       oversize
);

    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    // The length counter saturates at 2047, so MAX_LEN must stay strictly below it.
    if (MIN_LEN < 1 || MIN_LEN > MAX_LEN || MAX_LEN > 2046) begin : g_param_check
        $error("eth_fcs_checker: illegal MIN_LEN/MAX_LEN");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t          state;
    logic [31:0]     crc;
    logic [31:0]     crc_next;
    logic [3:0][7:0] dly;
    logic [1:0]      fill_cnt;
    logic            rel_byte;
    logic            is_runt;
    logic            is_over;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc_in, input logic [7:0] d);
        logic [31:0] c;
        c = crc_in ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    always_comb begin
        crc_next = crc_byte(crc, s_data);
        // dly[3] is the byte accepted four beats ago once four bytes are buffered
        rel_byte = (state == STREAM) || ((state == FILL) && (fill_cnt == 2'd3));
    end

`ifdef ETH_FCS_CHECK_LEN_EN
    localparam logic [10:0] MIN_LEN_W = 11'(MIN_LEN);
    localparam logic [10:0] MAX_LEN_W = 11'(MAX_LEN);

    logic [10:0] byte_cnt;
    logic [10:0] len_now;

    always_comb begin
        len_now = (byte_cnt == 11'h7FF) ? 11'h7FF : byte_cnt + 11'd1;
        is_runt = (len_now < MIN_LEN_W);
        is_over = (len_now > MAX_LEN_W);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_cnt <= 11'd0;
        end else if (s_valid) begin
            byte_cnt <= s_last ? 11'd0 : len_now;
        end
    end
`else
    assign is_runt = 1'b0;
    assign is_over = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            crc        <= CRC_INIT;
            dly        <= '0;
            fill_cnt   <= 2'd0;
            m_data     <= 8'h00;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            frame_done <= 1'b0;
            fcs_ok     <= 1'b0;
            runt       <= 1'b0;
            oversize   <= 1'b0;
        end else begin
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            frame_done <= 1'b0;
            if (s_valid) begin
                dly <= {dly[2:0], s_data};
                if (rel_byte) begin
                    m_data  <= dly[3];
                    m_valid <= 1'b1;
                    m_last  <= s_last;
                end
                if (s_last) begin
                    state      <= IDLE;
                    crc        <= CRC_INIT;
                    fill_cnt   <= 2'd0;
                    frame_done <= 1'b1;
                    fcs_ok     <= (crc_next == CRC_RESIDUE);
                    runt       <= is_runt;
                    oversize   <= is_over;
                end else begin
                    crc <= crc_next;
                    case (state)
                        IDLE: begin
                            state    <= FILL;
                            fill_cnt <= 2'd0;
                        end
                        FILL: begin
                            if (fill_cnt == 2'd3) begin
                                state <= STREAM;
                            end else begin
                                fill_cnt <= fill_cnt + 2'd1;
                            end
                        end
                        STREAM: ;
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_eth_fcs_checker.sv
// Randomised bench for eth_fcs_checker against a frame-level reference model.
module tb_eth_fcs_checker;

    localparam int MAX_LEN = 1518;
    localparam int MIN_LEN = 64;
`ifdef ETH_FCS_CHECK_LEN_EN
    localparam bit LEN_EN = 1'b1;
`else
    localparam bit LEN_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       frame_done;
    logic       fcs_ok;
    logic       runt;
    logic       oversize;

    eth_fcs_checker #(.MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .frame_done(frame_done),
        .fcs_ok(fcs_ok), .runt(runt), .oversize(oversize)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int bad_vld = 0;
    logic prev_sv = 1'b0;

    logic [7:0] got_d[$];
    logic       got_l[$];
    logic [3:0] got_s[$];
    logic [7:0] exp_d[$];
    logic       exp_l[$];
    logic [3:0] exp_s[$];
    logic [3:0] exp_m[$];

    always @(posedge clk) prev_sv <= s_valid && rst_n;

    // Status record: {m_last, fcs_ok, runt, oversize} seen with frame_done
    always @(negedge clk) begin
        if (m_valid) begin
            got_d.push_back(m_data);
            got_l.push_back(m_last);
            if (!prev_sv) bad_vld++;
        end
        if (frame_done) got_s.push_back({m_last, fcs_ok, runt, oversize});
    end

    task automatic clear_all();
        got_d.delete(); got_l.delete(); got_s.delete();
        exp_d.delete(); exp_l.delete(); exp_s.delete(); exp_m.delete();
        bad_vld = 0;
    endtask

    // Standard Ethernet CRC-32 (reflected, final complement) over the first n bytes
    function automatic logic [31:0] crc32(input logic [7:0] d[$], input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, d[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic make_frame(input int n, input bit corrupt, output logic [7:0] f[$]);
        logic [31:0] fcs;
        int idx;
        f.delete();
        if (n < 4) begin
            for (int i = 0; i < n; i++) f.push_back(8'($urandom));
        end else begin
            for (int i = 0; i < n - 4; i++) f.push_back(8'($urandom));
            fcs = crc32(f, n - 4);
            f.push_back(fcs[7:0]); f.push_back(fcs[15:8]);
            f.push_back(fcs[23:16]); f.push_back(fcs[31:24]);
            if (corrupt) begin
                idx = $urandom_range(0, n - 1);
                f[idx] = f[idx] ^ (8'h01 << $urandom_range(0, 7));
            end
        end
    endtask

    // Model: payload is all but the trailing four bytes; FCS good iff it equals CRC of the rest
    task automatic expect_frame(input logic [7:0] f[$]);
        int n;
        bit ok;
        n = f.size();
        for (int i = 0; i < n - 4; i++) begin
            exp_d.push_back(f[i]);
            exp_l.push_back(i == n - 5);
        end
        ok = 1'b0;
        if (n >= 4) ok = (crc32(f, n - 4) == {f[n-1], f[n-2], f[n-3], f[n-4]});
        exp_s.push_back({n >= 5, ok, LEN_EN && (n < MIN_LEN), LEN_EN && (n > MAX_LEN)});
        exp_m.push_back((n >= 4) ? 4'hF : 4'hB);
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clk); #2;
            s_valid = 1'b0;
            s_data  = 8'($urandom);
            s_last  = 1'($urandom);
        end
    endtask

    // gap_mode: 0 none, 1 idle before every byte after the first, 2 random idles
    task automatic send(input logic [7:0] f[$], input int gap_mode, input bit with_last);
        for (int i = 0; i < f.size(); i++) begin
            if (gap_mode == 1 && i > 0) idle(1);
            if (gap_mode == 2) idle($urandom_range(0, 2));
            @(posedge clk); #2;
            s_valid = 1'b1;
            s_data  = f[i];
            s_last  = with_last && (i == f.size() - 1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) begin
            @(posedge clk); #2;
            s_valid = 1'b1; s_data = 8'($urandom); s_last = 1'b1;
        end
        @(negedge clk);
        n_chk++;
        if ({m_data, m_valid, m_last, frame_done} !== 11'h0) begin
            n_err++;
            $display("FAIL reset_data: got %h/%b/%b/%b, expected 00/0/0/0", m_data, m_valid, m_last, frame_done);
        end
        n_chk++;
        if ({fcs_ok, runt, oversize} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_status: got %b, expected 000", {fcs_ok, runt, oversize});
        end
        @(posedge clk); #2;
        rst_n = 1'b1; s_valid = 1'b0; s_last = 1'b0;
        idle(2);
        n_chk++;
        if (got_d.size() != 0 || got_s.size() != 0) begin
            n_err++;
            $display("FAIL reset_quiet: got %0d beats %0d done, expected 0 0", got_d.size(), got_s.size());
        end
        clear_all();
    endtask

    task automatic test_known_vector();
        logic [7:0] f[$];
        clear_all();
        f = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};
        expect_frame(f);
        send(f, 0, 1'b1);
        idle(2);
        f[12] = 8'hCA;
        expect_frame(f);
        send(f, 2, 1'b1);
        idle(3);
        n_chk++;
        if (got_d.size() != exp_d.size()) begin
            n_err++; $display("FAIL vec_beats: got %0d, expected %0d", got_d.size(), exp_d.size());
        end
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            n_chk++;
            if ({got_l[i], got_d[i]} !== {exp_l[i], exp_d[i]}) begin
                n_err++; $display("FAIL vec_beat[%0d]: got %b/%h, expected %b/%h", i, got_l[i], got_d[i], exp_l[i], exp_d[i]);
            end
        end
        n_chk++;
        if (got_s.size() != exp_s.size()) begin
            n_err++; $display("FAIL vec_done: got %0d, expected %0d", got_s.size(), exp_s.size());
        end
        for (int i = 0; i < got_s.size() && i < exp_s.size(); i++) begin
            n_chk++;
            if ((got_s[i] & exp_m[i]) !== (exp_s[i] & exp_m[i])) begin
                n_err++; $display("FAIL vec_status[%0d]: got %b, expected %b", i, got_s[i], exp_s[i]);
            end
        end
    endtask

    task automatic test_gapped();
        logic [7:0] f[$];
        clear_all();
        make_frame(64, 1'b0, f);
        expect_frame(f);
        send(f, 1, 1'b1);
        for (int j = 0; j < 6; j++) begin
            make_frame($urandom_range(5, 90), 1'($urandom), f);
            expect_frame(f);
            send(f, 2, 1'b1);
        end
        idle(3);
        n_chk++;
        if (got_d.size() != exp_d.size()) begin
            n_err++; $display("FAIL gap_beats: got %0d, expected %0d", got_d.size(), exp_d.size());
        end
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            n_chk++;
            if ({got_l[i], got_d[i]} !== {exp_l[i], exp_d[i]}) begin
                n_err++; $display("FAIL gap_beat[%0d]: got %b/%h, expected %b/%h", i, got_l[i], got_d[i], exp_l[i], exp_d[i]);
            end
        end
        n_chk++;
        if (got_s.size() != exp_s.size()) begin
            n_err++; $display("FAIL gap_done: got %0d, expected %0d", got_s.size(), exp_s.size());
        end
        for (int i = 0; i < got_s.size() && i < exp_s.size(); i++) begin
            n_chk++;
            if ((got_s[i] & exp_m[i]) !== (exp_s[i] & exp_m[i])) begin
                n_err++; $display("FAIL gap_status[%0d]: got %b, expected %b", i, got_s[i], exp_s[i]);
            end
        end
        n_chk++;
        if (bad_vld != 0) begin
            n_err++; $display("FAIL gap_idle_valid: got %0d beats on idle cycles, expected 0", bad_vld);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] f[$];
        clear_all();
        for (int j = 0; j < 2; j++) begin
            make_frame(64, 1'b0, f);
            expect_frame(f);
            send(f, 0, 1'b1);
        end
        for (int j = 0; j < 8; j++) begin
            make_frame($urandom_range(1, 100), ($urandom_range(0, 3) == 0), f);
            expect_frame(f);
            send(f, 0, 1'b1);
        end
        idle(3);
        n_chk++;
        if (got_d.size() != exp_d.size()) begin
            n_err++; $display("FAIL b2b_beats: got %0d, expected %0d", got_d.size(), exp_d.size());
        end
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            n_chk++;
            if ({got_l[i], got_d[i]} !== {exp_l[i], exp_d[i]}) begin
                n_err++; $display("FAIL b2b_beat[%0d]: got %b/%h, expected %b/%h", i, got_l[i], got_d[i], exp_l[i], exp_d[i]);
            end
        end
        n_chk++;
        if (got_s.size() != exp_s.size()) begin
            n_err++; $display("FAIL b2b_done: got %0d, expected %0d", got_s.size(), exp_s.size());
        end
        for (int i = 0; i < got_s.size() && i < exp_s.size(); i++) begin
            n_chk++;
            if ((got_s[i] & exp_m[i]) !== (exp_s[i] & exp_m[i])) begin
                n_err++; $display("FAIL b2b_status[%0d]: got %b, expected %b", i, got_s[i], exp_s[i]);
            end
        end
    endtask

    task automatic test_length();
        logic [7:0] f[$];
        int lens[10];
        lens = '{63, 64, 1, 2, 3, 4, 5, 1518, 1519, 2100};
        clear_all();
        foreach (lens[j]) begin
            make_frame(lens[j], 1'b0, f);
            expect_frame(f);
            send(f, 0, 1'b1);
            idle(1);
        end
        make_frame(64, 1'b0, f);
        expect_frame(f);
        send(f, 0, 1'b1);
        idle(3);
        n_chk++;
        if (got_d.size() != exp_d.size()) begin
            n_err++; $display("FAIL len_beats: got %0d, expected %0d", got_d.size(), exp_d.size());
        end
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            n_chk++;
            if ({got_l[i], got_d[i]} !== {exp_l[i], exp_d[i]}) begin
                n_err++; $display("FAIL len_beat[%0d]: got %b/%h, expected %b/%h", i, got_l[i], got_d[i], exp_l[i], exp_d[i]);
            end
        end
        n_chk++;
        if (got_s.size() != exp_s.size()) begin
            n_err++; $display("FAIL len_done: got %0d, expected %0d", got_s.size(), exp_s.size());
        end
        for (int i = 0; i < got_s.size() && i < exp_s.size(); i++) begin
            n_chk++;
            if ((got_s[i] & exp_m[i]) !== (exp_s[i] & exp_m[i])) begin
                n_err++; $display("FAIL len_status[%0d]: got %b, expected %b", i, got_s[i], exp_s[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] f[$];
        logic [7:0] part[$];
        clear_all();
        make_frame(64, 1'b0, f);
        part = f[0:28];
        send(part, 0, 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b0; s_valid = 1'b1; s_data = f[29]; s_last = 1'b0;
        @(posedge clk); #2;
        s_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        idle(2);
        n_chk++;
        if (got_s.size() != 0) begin
            n_err++; $display("FAIL rst_partial_done: got %0d frame_done, expected 0", got_s.size());
        end
        clear_all();
        make_frame(70, 1'b0, f);
        expect_frame(f);
        send(f, 0, 1'b1);
        idle(3);
        n_chk++;
        if (got_d.size() != exp_d.size()) begin
            n_err++; $display("FAIL rst_beats: got %0d, expected %0d", got_d.size(), exp_d.size());
        end
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            n_chk++;
            if ({got_l[i], got_d[i]} !== {exp_l[i], exp_d[i]}) begin
                n_err++; $display("FAIL rst_beat[%0d]: got %b/%h, expected %b/%h", i, got_l[i], got_d[i], exp_l[i], exp_d[i]);
            end
        end
        n_chk++;
        if (got_s.size() != 1 || exp_s.size() != 1) begin
            n_err++; $display("FAIL rst_done: got %0d, expected 1", got_s.size());
        end else begin
            n_chk++;
            if (got_s[0] !== exp_s[0]) begin
                n_err++; $display("FAIL rst_status: got %b, expected %b", got_s[0], exp_s[0]);
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
        test_reset();
        test_known_vector();
        test_gapped();
        test_back_to_back();
        test_length();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
